// File: rtl/alu_share_arbiter_if.sv
// Requester and response handshake bundle for alu_share_arbiter.
// master = issue logic / response consumer side, slave = the arbiter.
interface alu_share_arbiter_if #(
  parameter int DATA_W = 32
);
  logic              r0_valid;
  logic              r0_ready;
  logic [3:0]        r0_op;
  logic [DATA_W-1:0] r0_a;
  logic [DATA_W-1:0] r0_b;
  logic              r1_valid;
  logic              r1_ready;
  logic [3:0]        r1_op;
  logic [DATA_W-1:0] r1_a;
  logic [DATA_W-1:0] r1_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [DATA_W-1:0] rsp_c;
  logic              rsp_branch;

  modport master (
    output r0_valid, r0_op, r0_a, r0_b,
    output r1_valid, r1_op, r1_a, r1_b,
    output rsp_ready,
    input  r0_ready, r1_ready,
    input  rsp_valid, rsp_id, rsp_c, rsp_branch
  );

  modport slave (
    input  r0_valid, r0_op, r0_a, r0_b,
    input  r1_valid, r1_op, r1_a, r1_b,
    input  rsp_ready,
    output r0_ready, r1_ready,
    output rsp_valid, rsp_id, rsp_c, rsp_branch
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one combinational ALU between two requesters.
// Define ALU_ARB_PERF_EN to add per-requester grant counters (perf_cnt0/perf_cnt1).
//
// state | meaning
// IDLE  | arbitrate; accept at most one request
// EXEC  | ALU settles on registered op/a/b; result captured at end of cycle
// RESP  | response held until rsp_ready
module alu_share_arbiter #(
  parameter int DATA_W = 32
`ifdef ALU_ARB_PERF_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_share_arbiter_if.slave   bus,
  output logic [3:0]           alu_op,
  output logic [DATA_W-1:0]    alu_a,
  output logic [DATA_W-1:0]    alu_b,
  input  logic [DATA_W-1:0]    alu_c,
  input  logic                 alu_branch
`ifdef ALU_ARB_PERF_EN
  , output logic [CNT_W-1:0]   perf_cnt0,
  output logic [CNT_W-1:0]     perf_cnt1
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state, state_nxt;
  logic   last_grant;
  logic   take;
  logic   take_id;
  logic   is_branch_op;

  // Opcodes 0xA-0xF only drive branch; 0x0-0x9 only drive C.
  assign is_branch_op = (alu_op >= 4'hA);

  always_comb begin
    state_nxt    = state;
    bus.r0_ready = 1'b0;
    bus.r1_ready = 1'b0;
    take         = 1'b0;
    take_id      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.r0_valid && (!bus.r1_valid || last_grant)) begin
          bus.r0_ready = 1'b1;
          take         = 1'b1;
        end else if (bus.r1_valid) begin
          bus.r1_ready = 1'b1;
          take         = 1'b1;
          take_id      = 1'b1;
        end
        if (take) state_nxt = EXEC;
      end
      EXEC: state_nxt = RESP;
      RESP: if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      last_grant     <= 1'b1;
      alu_op         <= '0;
      alu_a          <= '0;
      alu_b          <= '0;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_id     <= 1'b0;
      bus.rsp_c      <= '0;
      bus.rsp_branch <= 1'b0;
    end else begin
      state <= state_nxt;
      if (take) begin
        last_grant <= take_id;
        bus.rsp_id <= take_id;
        alu_op     <= take_id ? bus.r1_op : bus.r0_op;
        alu_a      <= take_id ? bus.r1_a  : bus.r0_a;
        alu_b      <= take_id ? bus.r1_b  : bus.r0_b;
      end
      if (state == EXEC) begin
        bus.rsp_valid  <= 1'b1;
        bus.rsp_c      <= is_branch_op ? '0 : alu_c;
        bus.rsp_branch <= is_branch_op & alu_branch;
      end else if (state == RESP && bus.rsp_ready) begin
        bus.rsp_valid  <= 1'b0;
      end
    end
  end

`ifdef ALU_ARB_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cnt0 <= '0;
      perf_cnt1 <= '0;
    end else if (take) begin
      if (take_id) perf_cnt1 <= perf_cnt1 + 1'b1;
      else         perf_cnt0 <= perf_cnt0 + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed scenarios, then randomized traffic
// against a transaction-level reference. Perf counter checks apply when ALU_ARB_PERF_EN is defined.
module tb_alu_share_arbiter;
  localparam int DATA_W = 32;
`ifdef ALU_ARB_PERF_EN
  localparam int CNT_W = 2;
  logic [CNT_W-1:0] perf_cnt0, perf_cnt1;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [3:0]        alu_op;
  logic [DATA_W-1:0] alu_a, alu_b, alu_c;
  logic              alu_branch;
  logic [32:0]       alu_raw;
  int checks = 0;
  int errors = 0;

  alu_share_arbiter_if #(.DATA_W(DATA_W)) bus ();

  alu_share_arbiter #(
    .DATA_W(DATA_W)
`ifdef ALU_ARB_PERF_EN
    , .CNT_W(CNT_W)
`endif
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .alu_op(alu_op),
    .alu_a(alu_a),
    .alu_b(alu_b),
    .alu_c(alu_c),
    .alu_branch(alu_branch)
`ifdef ALU_ARB_PERF_EN
    , .perf_cnt0(perf_cnt0),
    .perf_cnt1(perf_cnt1)
`endif
  );

  always #5 clk = ~clk;

  // True ALU semantics, returned as {branch, c}.
  function automatic logic [32:0] alu_true(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] c;
    logic        br;
    c  = '0;
    br = 1'b0;
    case (op)
      4'h0: c = a + b;
      4'h1: c = a - b;
      4'h2: c = a & b;
      4'h3: c = a | b;
      4'h4: c = a ^ b;
      4'h5: c = a << b[4:0];
      4'h6: c = a >> b[4:0];
      4'h7: c = $signed(a) >>> b[4:0];
      4'h8: c = ~(a | b);
      4'h9: c = b;
      4'hA: br = (a == b);
      4'hB: br = (a != b);
      4'hC: br = ($signed(a) < $signed(b));
      4'hD: br = (a < b);
      4'hE: br = ($signed(a) >= $signed(b));
      default: br = (a >= b);
    endcase
    return {br, c};
  endfunction

  // Stand-in ALU: garbage on the output each opcode leaves unused.
  always_comb begin
    alu_raw = alu_true(alu_op, alu_a, alu_b);
    if (alu_op < 4'hA) begin
      alu_c      = alu_raw[31:0];
      alu_branch = 1'b1;
    end else begin
      alu_c      = alu_a ^ alu_b ^ 32'hDEADBEEF;
      alu_branch = alu_raw[32];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit id, input bit v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    if (id) begin
      bus.r1_valid = v; bus.r1_op = op; bus.r1_a = a; bus.r1_b = b;
    end else begin
      bus.r0_valid = v; bus.r0_op = op; bus.r0_a = a; bus.r0_b = b;
    end
  endtask

  task automatic do_op(input bit id, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int stall, input logic [31:0] ec, input logic eb);
    int n;
    drive(id, 1'b1, op, a, b);
    bus.rsp_ready = 1'b0;
    #1;
    n = 0;
    while (!(id ? bus.r1_ready : bus.r0_ready) && n < 8) begin
      @(negedge clk); #1; n++;
    end
    chk("grant_lat", n, 0);
    chk("other_ready", id ? bus.r0_ready : bus.r1_ready, 0);
    @(negedge clk);
    drive(id, 1'b0, op, a, b);
    #1;
    chk("exec_no_valid", bus.rsp_valid, 0);
    chk("alu_op", alu_op, op);
    chk("alu_a", alu_a, a);
    chk("alu_b", alu_b, b);
    @(negedge clk); #1;
    chk("rsp_valid", bus.rsp_valid, 1);
    chk("rsp_id", bus.rsp_id, id);
    chk("rsp_c", bus.rsp_c, ec);
    chk("rsp_branch", bus.rsp_branch, eb);
    for (int i = 0; i < stall; i++) begin
      bus.r0_valid = 1'b1;
      bus.r1_valid = 1'b1;
      @(negedge clk); #1;
      chk("stall_valid", bus.rsp_valid, 1);
      chk("stall_c", bus.rsp_c, ec);
      chk("stall_branch", bus.rsp_branch, eb);
      chk("stall_ready", {bus.r1_ready, bus.r0_ready}, 0);
    end
    bus.r0_valid  = 1'b0;
    bus.r1_valid  = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    #1;
    chk("retired", bus.rsp_valid, 0);
  endtask

  initial begin
    int          n;
    bit          exp_w;
    bit          p0, p1, lg, w0, w1, have_acc, wid;
    logic [3:0]  o0, o1, e_op;
    logic [31:0] a0, b0, a1, b1, e_a, e_b, e_c;
    logic        e_br;
    logic [32:0] ar;
    int          since, g0, g1;

    drive(0, 1'b0, 4'h0, 0, 0);
    drive(1, 1'b0, 4'h0, 0, 0);
    bus.rsp_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_r0_ready", bus.r0_ready, 0);
    chk("rst_r1_ready", bus.r1_ready, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_id", bus.rsp_id, 0);
    chk("rst_rsp_c", bus.rsp_c, 0);
    chk("rst_rsp_branch", bus.rsp_branch, 0);
    chk("rst_alu", {alu_op, alu_a, alu_b}, 0);
`ifdef ALU_ARB_PERF_EN
    chk("rst_perf", {perf_cnt1, perf_cnt0}, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Basic add, branch ops with masking, stalled response
    do_op(0, 4'h0, 32'd5, 32'd7, 0, 32'd12, 1'b0);
    do_op(1, 4'hA, 32'h1234, 32'h1234, 0, 32'd0, 1'b1);
    do_op(1, 4'hC, 32'hFFFFFFFF, 32'd1, 0, 32'd0, 1'b1);
    do_op(1, 4'hD, 32'hFFFFFFFF, 32'd1, 0, 32'd0, 1'b0);
    do_op(0, 4'h1, 32'd100, 32'd30, 5, 32'd70, 1'b0);

    // Reset while in EXEC aborts the operation
    drive(0, 1'b1, 4'h0, 32'd1, 32'd2);
    #1;
    chk("abort_grant", bus.r0_ready, 1);
    @(negedge clk);
    drive(0, 1'b0, 4'h0, 32'd1, 32'd2);
    rst_n = 1'b0;
    #1;
    chk("abort_no_valid", bus.rsp_valid, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk); #1;
      chk("abort_still_idle", bus.rsp_valid, 0);
    end

    // Tie: both hold valid, grants alternate starting with requester 0
    drive(0, 1'b1, 4'h0, 32'd10, 32'd1);
    drive(1, 1'b1, 4'h1, 32'd10, 32'd1);
    bus.rsp_ready = 1'b1;
    exp_w = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      n = 0;
      while (!(bus.r0_ready || bus.r1_ready) && n < 8) begin
        @(negedge clk); #1; n++;
      end
      chk("tie_grant", {bus.r1_ready, bus.r0_ready}, exp_w ? 2'b10 : 2'b01);
      @(negedge clk);
      @(negedge clk); #1;
      chk("tie_rsp_id", bus.rsp_id, exp_w);
      chk("tie_rsp_c", bus.rsp_c, exp_w ? 32'd9 : 32'd11);
      @(negedge clk);
      exp_w = ~exp_w;
    end
    drive(0, 1'b0, 4'h0, 0, 0);
    drive(1, 1'b0, 4'h0, 0, 0);
    bus.rsp_ready = 1'b0;

`ifdef ALU_ARB_PERF_EN
    // Five grants to requester 0 wrap a 2-bit counter to 1
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) do_op(0, 4'h2, 32'hF0F0, 32'hFF00, 0, 32'hF000, 1'b0);
    chk("perf_wrap0", perf_cnt0, 1);
    chk("perf_wrap1", perf_cnt1, 0);
`endif

    // Randomized traffic against a transaction-level reference
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    p0 = 0; p1 = 0; lg = 1; since = -1; have_acc = 0; g0 = 0; g1 = 0;
    o0 = '0; o1 = '0; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    e_op = '0; e_a = '0; e_b = '0; e_c = '0; e_br = 1'b0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(negedge clk);
      if (!p0 && $urandom_range(0, 2) == 0) begin
        p0 = 1; o0 = 4'($urandom_range(0, 15)); a0 = $urandom;
        b0 = ($urandom_range(0, 3) == 0) ? a0 : $urandom;
      end else if (p0 && $urandom_range(0, 19) == 0) begin
        p0 = 0;
      end
      if (!p1 && $urandom_range(0, 2) == 0) begin
        p1 = 1; o1 = 4'($urandom_range(0, 15)); a1 = $urandom;
        b1 = ($urandom_range(0, 3) == 0) ? a1 : $urandom;
      end else if (p1 && $urandom_range(0, 19) == 0) begin
        p1 = 0;
      end
      drive(0, p0, o0, a0, b0);
      drive(1, p1, o1, a1, b1);
      bus.rsp_ready = 1'($urandom_range(0, 1));
      #1;
      w0 = (since < 0) && p0 && (!p1 || lg);
      w1 = (since < 0) && p1 && !w0;
      chk("rnd_r0_ready", bus.r0_ready, w0);
      chk("rnd_r1_ready", bus.r1_ready, w1);
      chk("rnd_rsp_valid", bus.rsp_valid, since >= 2);
      if (since >= 2) begin
        chk("rnd_rsp_id", bus.rsp_id, wid);
        chk("rnd_rsp_c", bus.rsp_c, e_c);
        chk("rnd_rsp_branch", bus.rsp_branch, e_br);
      end
      if (have_acc) chk("rnd_alu_regs", {alu_op, alu_a, alu_b}, {e_op, e_a, e_b});
`ifdef ALU_ARB_PERF_EN
      chk("rnd_perf", {perf_cnt1, perf_cnt0}, {2'(g1 % 4), 2'(g0 % 4)});
`endif
      if (since >= 2 && bus.rsp_ready) begin
        since = -1;
      end else if (since >= 1) begin
        since++;
      end else if (w0 || w1) begin
        wid  = w1;
        e_op = w1 ? o1 : o0;
        e_a  = w1 ? a1 : a0;
        e_b  = w1 ? b1 : b0;
        ar   = alu_true(e_op, e_a, e_b);
        e_c  = (e_op < 4'hA) ? ar[31:0] : 32'd0;
        e_br = (e_op >= 4'hA) ? ar[32] : 1'b0;
        lg = w1; since = 1; have_acc = 1;
        if (w1) begin p1 = 0; g1++; end
        else    begin p0 = 0; g0++; end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
